// File: rtl/k6502_pkg.sv
//------------------------------------------------------------------------------
// Module   : k6502_pkg
// Purpose  : Shared types and constants for the k6502 core: sequencer states,
//            ALU operations, opcode values and status-register bit positions.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package k6502_pkg;

    typedef enum logic [2:0] {
        VEC_LO, VEC_HI, FETCH, T1, T2, T3, HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS, ALU_ADC, ALU_AND, ALU_ORA, ALU_EOR, ALU_CMP, ALU_INC, ALU_DEC
    } alu_op_t;

    localparam logic [7:0] c_op_nop     = 8'hEA;
    localparam logic [7:0] c_op_lda_imm = 8'hA9;
    localparam logic [7:0] c_op_ldx_imm = 8'hA2;
    localparam logic [7:0] c_op_ldy_imm = 8'hA0;
    localparam logic [7:0] c_op_lda_abs = 8'hAD;
    localparam logic [7:0] c_op_ldx_abs = 8'hAE;
    localparam logic [7:0] c_op_ldy_abs = 8'hAC;
    localparam logic [7:0] c_op_tax     = 8'hAA;
    localparam logic [7:0] c_op_tay     = 8'hA8;
    localparam logic [7:0] c_op_txa     = 8'h8A;
    localparam logic [7:0] c_op_tya     = 8'h98;
    localparam logic [7:0] c_op_inx     = 8'hE8;
    localparam logic [7:0] c_op_iny     = 8'hC8;
    localparam logic [7:0] c_op_dex     = 8'hCA;
    localparam logic [7:0] c_op_dey     = 8'h88;
    localparam logic [7:0] c_op_adc_imm = 8'h69;
    localparam logic [7:0] c_op_and_imm = 8'h29;
    localparam logic [7:0] c_op_ora_imm = 8'h09;
    localparam logic [7:0] c_op_eor_imm = 8'h49;
    localparam logic [7:0] c_op_cmp_imm = 8'hC9;
    localparam logic [7:0] c_op_clc     = 8'h18;
    localparam logic [7:0] c_op_sec     = 8'h38;
    localparam logic [7:0] c_op_jmp_abs = 8'h4C;
    localparam logic [7:0] c_op_bpl     = 8'h10;
    localparam logic [7:0] c_op_bmi     = 8'h30;
    localparam logic [7:0] c_op_bcc     = 8'h90;
    localparam logic [7:0] c_op_bcs     = 8'hB0;
    localparam logic [7:0] c_op_bne     = 8'hD0;
    localparam logic [7:0] c_op_beq     = 8'hF0;

    localparam int c_p_c = 0;
    localparam int c_p_z = 1;
    localparam int c_p_i = 2;
    localparam int c_p_d = 3;
    localparam int c_p_v = 6;
    localparam int c_p_n = 7;

    function automatic logic is_defined(input logic [7:0] op);
        case (op)
            c_op_nop, c_op_lda_imm, c_op_ldx_imm, c_op_ldy_imm,
            c_op_lda_abs, c_op_ldx_abs, c_op_ldy_abs,
            c_op_tax, c_op_tay, c_op_txa, c_op_tya,
            c_op_inx, c_op_iny, c_op_dex, c_op_dey,
            c_op_adc_imm, c_op_and_imm, c_op_ora_imm, c_op_eor_imm, c_op_cmp_imm,
            c_op_clc, c_op_sec, c_op_jmp_abs,
            c_op_bpl, c_op_bmi, c_op_bcc, c_op_bcs, c_op_bne, c_op_beq: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/k6502_alu.sv
//------------------------------------------------------------------------------
// Module   : k6502_alu
// Purpose  : Combinational 8-bit ALU (binary ADC, logic ops, compare, inc/dec).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module k6502_alu
    import k6502_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    input  logic [2:0] op,
    output logic [7:0] result,
    output logic       n,
    output logic       z,
    output logic       c,
    output logic       v
);

    logic [8:0] w_sum;
    logic [8:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        w_diff = {1'b0, a} - {1'b0, b};
        result = b;
        c      = ci;
        v      = 1'b0;
        case (op)
            ALU_ADC: begin
                result = w_sum[7:0];
                c      = w_sum[8];
                v      = (a[7] == b[7]) && (w_sum[7] != a[7]);
            end
            ALU_AND: result = a & b;
            ALU_ORA: result = a | b;
            ALU_EOR: result = a ^ b;
            // Borrow out of A-imm is the inverse of the 6502 carry.
            ALU_CMP: begin
                result = w_diff[7:0];
                c      = ~w_diff[8];
            end
            ALU_INC: result = a + 8'd1;
            ALU_DEC: result = a - 8'd1;
            default: result = b;
        endcase
        n = result[7];
        z = (result == 8'd0);
    end

endmodule

`default_nettype wire

// File: rtl/k6502_core.sv
//------------------------------------------------------------------------------
// Module   : k6502_core
// Purpose  : Minimal 6502-subset CPU with read-only bus and cycle-accurate
//            sequencing. Define K6502_UNDEF_HALT_EN to halt on undefined opcodes.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module k6502_core
    import k6502_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] a,
    input  logic [7:0]  d,
    output logic        sync
);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    logic [7:0]  r_ir, w_ir_nxt;
    logic [7:0]  r_lo, w_lo_nxt;
    logic [7:0]  r_hi, w_hi_nxt;
    logic [7:0]  r_a, r_x, r_y, r_p;
    logic [7:0]  w_a_nxt, w_x_nxt, w_y_nxt, w_p_nxt;

    logic [7:0]  w_alu_a, w_alu_b, w_alu_res;
    logic        w_alu_ci, w_alu_n, w_alu_z, w_alu_c, w_alu_v;
    alu_op_t     w_alu_op;
    logic        w_wr_a, w_wr_x, w_wr_y, w_wr_nz, w_wr_c, w_wr_v;

    function automatic logic f_branch_taken(input logic [7:0] op, input logic [7:0] p);
        case (op)
            c_op_bpl: return ~p[c_p_n];
            c_op_bmi: return  p[c_p_n];
            c_op_bcc: return ~p[c_p_c];
            c_op_bcs: return  p[c_p_c];
            c_op_bne: return ~p[c_p_z];
            c_op_beq: return  p[c_p_z];
            default:  return 1'b0;
        endcase
    endfunction

    k6502_alu u_alu (
        .a      (w_alu_a),
        .b      (w_alu_b),
        .ci     (w_alu_ci),
        .op     (w_alu_op),
        .result (w_alu_res),
        .n      (w_alu_n),
        .z      (w_alu_z),
        .c      (w_alu_c),
        .v      (w_alu_v)
    );

    assign sync = (r_state == FETCH);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_lo_nxt    = r_lo;
        w_hi_nxt    = r_hi;
        a           = r_pc;
        w_alu_a     = r_a;
        w_alu_b     = d;
        w_alu_ci    = r_p[c_p_c];
        w_alu_op    = ALU_PASS;
        w_wr_a      = 1'b0;
        w_wr_x      = 1'b0;
        w_wr_y      = 1'b0;
        w_wr_nz     = 1'b0;
        w_wr_c      = 1'b0;
        w_wr_v      = 1'b0;
        case (r_state)
            VEC_LO: begin
                a              = RESET_VECTOR;
                w_pc_nxt[7:0]  = d;
                w_state_nxt    = VEC_HI;
            end
            VEC_HI: begin
                a              = RESET_VECTOR + 16'd1;
                w_pc_nxt[15:8] = d;
                w_state_nxt    = FETCH;
            end
            FETCH: begin
                w_ir_nxt    = d;
                w_pc_nxt    = r_pc + 16'd1;
`ifdef K6502_UNDEF_HALT_EN
                w_state_nxt = is_defined(d) ? T1 : HALT;
`else
                w_state_nxt = T1;
`endif
            end
            T1: begin
                w_state_nxt = FETCH;
                case (r_ir)
                    c_op_lda_imm: begin w_pc_nxt = r_pc + 16'd1; w_wr_a = 1'b1; w_wr_nz = 1'b1; end
                    c_op_ldx_imm: begin w_pc_nxt = r_pc + 16'd1; w_wr_x = 1'b1; w_wr_nz = 1'b1; end
                    c_op_ldy_imm: begin w_pc_nxt = r_pc + 16'd1; w_wr_y = 1'b1; w_wr_nz = 1'b1; end
                    c_op_adc_imm: begin
                        w_pc_nxt = r_pc + 16'd1; w_alu_op = ALU_ADC;
                        w_wr_a = 1'b1; w_wr_nz = 1'b1; w_wr_c = 1'b1; w_wr_v = 1'b1;
                    end
                    c_op_and_imm: begin w_pc_nxt = r_pc + 16'd1; w_alu_op = ALU_AND; w_wr_a = 1'b1; w_wr_nz = 1'b1; end
                    c_op_ora_imm: begin w_pc_nxt = r_pc + 16'd1; w_alu_op = ALU_ORA; w_wr_a = 1'b1; w_wr_nz = 1'b1; end
                    c_op_eor_imm: begin w_pc_nxt = r_pc + 16'd1; w_alu_op = ALU_EOR; w_wr_a = 1'b1; w_wr_nz = 1'b1; end
                    c_op_cmp_imm: begin w_pc_nxt = r_pc + 16'd1; w_alu_op = ALU_CMP; w_wr_nz = 1'b1; w_wr_c = 1'b1; end
                    c_op_tax: begin w_alu_b = r_a; w_wr_x = 1'b1; w_wr_nz = 1'b1; end
                    c_op_tay: begin w_alu_b = r_a; w_wr_y = 1'b1; w_wr_nz = 1'b1; end
                    c_op_txa: begin w_alu_b = r_x; w_wr_a = 1'b1; w_wr_nz = 1'b1; end
                    c_op_tya: begin w_alu_b = r_y; w_wr_a = 1'b1; w_wr_nz = 1'b1; end
                    c_op_inx: begin w_alu_a = r_x; w_alu_op = ALU_INC; w_wr_x = 1'b1; w_wr_nz = 1'b1; end
                    c_op_iny: begin w_alu_a = r_y; w_alu_op = ALU_INC; w_wr_y = 1'b1; w_wr_nz = 1'b1; end
                    c_op_dex: begin w_alu_a = r_x; w_alu_op = ALU_DEC; w_wr_x = 1'b1; w_wr_nz = 1'b1; end
                    c_op_dey: begin w_alu_a = r_y; w_alu_op = ALU_DEC; w_wr_y = 1'b1; w_wr_nz = 1'b1; end
                    // PASS forwards carry-in to carry-out, so CLC/SEC just pick the carry-in.
                    c_op_clc: begin w_alu_ci = 1'b0; w_wr_c = 1'b1; end
                    c_op_sec: begin w_alu_ci = 1'b1; w_wr_c = 1'b1; end
                    c_op_lda_abs, c_op_ldx_abs, c_op_ldy_abs, c_op_jmp_abs: begin
                        w_lo_nxt    = d;
                        w_pc_nxt    = r_pc + 16'd1;
                        w_state_nxt = T2;
                    end
                    c_op_bpl, c_op_bmi, c_op_bcc, c_op_bcs, c_op_bne, c_op_beq: begin
                        w_lo_nxt    = d;
                        w_pc_nxt    = r_pc + 16'd1;
                        w_state_nxt = f_branch_taken(r_ir, r_p) ? T2 : FETCH;
                    end
                    default: ;
                endcase
            end
            T2: begin
                w_state_nxt = FETCH;
                case (r_ir)
                    c_op_jmp_abs: w_pc_nxt = {d, r_lo};
                    c_op_lda_abs, c_op_ldx_abs, c_op_ldy_abs: begin
                        w_hi_nxt    = d;
                        w_pc_nxt    = r_pc + 16'd1;
                        w_state_nxt = T3;
                    end
                    default: w_pc_nxt = r_pc + {{8{r_lo[7]}}, r_lo};
                endcase
            end
            T3: begin
                a           = {r_hi, r_lo};
                w_wr_nz     = 1'b1;
                w_state_nxt = FETCH;
                case (r_ir)
                    c_op_ldx_abs: w_wr_x = 1'b1;
                    c_op_ldy_abs: w_wr_y = 1'b1;
                    default:      w_wr_a = 1'b1;
                endcase
            end
            HALT: w_state_nxt = HALT;
            default: w_state_nxt = VEC_LO;
        endcase
    end

    always_comb begin
        w_a_nxt = w_wr_a ? w_alu_res : r_a;
        w_x_nxt = w_wr_x ? w_alu_res : r_x;
        w_y_nxt = w_wr_y ? w_alu_res : r_y;
        w_p_nxt = r_p;
        if (w_wr_nz) begin
            w_p_nxt[c_p_n] = w_alu_n;
            w_p_nxt[c_p_z] = w_alu_z;
        end
        if (w_wr_c) w_p_nxt[c_p_c] = w_alu_c;
        if (w_wr_v) w_p_nxt[c_p_v] = w_alu_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= VEC_LO;
            r_pc    <= 16'h0000;
            r_ir    <= 8'h00;
            r_lo    <= 8'h00;
            r_hi    <= 8'h00;
            r_a     <= 8'h00;
            r_x     <= 8'h00;
            r_y     <= 8'h00;
            r_p     <= 8'h00 | (8'h01 << c_p_i);
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_lo    <= w_lo_nxt;
            r_hi    <= w_hi_nxt;
            r_a     <= w_a_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_p     <= w_p_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_k6502_core.sv
//------------------------------------------------------------------------------
// Module   : tb_k6502_core
// Purpose  : Directed self-checking bench for k6502_core with an async ROM model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_k6502_core;
    import k6502_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [7:0]  d;
    logic        sync;
    logic [7:0]  mem [0:65535];
    int          n_tests = 0;
    int          n_fail  = 0;

    k6502_core #(.RESET_VECTOR(16'hFFFC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .d     (d),
        .sync  (sync)
    );

    assign d = mem[a];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
    endtask

    task automatic load(input logic [63:0] bytes, input int n);
        logic [15:0] addr;
        for (int i = 0; i < n; i++) begin
            addr      = 16'h8000 + 16'(i);
            mem[addr] = bytes[63 - 8*i -: 8];
        end
    endtask

    // Leaves the bench at the first opcode fetch (a=8000, sync=1).
    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        check("rst_a", a, 16'hFFFC);
        check("rst_sync", {15'd0, sync}, 16'd0);
        step(1);
        check("rst_sync2", {15'd0, sync}, 16'd0);
        rst_n = 1'b1;
        check("vec_lo", a, 16'hFFFC);
        step(1);
        check("vec_hi", a, 16'hFFFD);
        check("vec_hi_sync", {15'd0, sync}, 16'd0);
        step(1);
        check("first_fetch", a, 16'h8000);
        check("first_sync", {15'd0, sync}, 16'd1);
    endtask

    initial begin
        rst_n = 1'b0;

        // Reset vector fetch and reset register state
        clear_mem();
        do_reset();
        check("rst_A", {8'd0, dut.r_a}, 16'h0000);
        check("rst_P_I", {15'd0, dut.r_p[c_p_i]}, 16'd1);

        // LDA #05 / TAX / INX / JMP $8000
        clear_mem();
        load(64'hA905AAE84C008000, 7);
        do_reset();
        step(1);
        check("lda_t1_a", a, 16'h8001);
        check("lda_t1_sync", {15'd0, sync}, 16'd0);
        step(1);
        check("tax_fetch", a, 16'h8002);
        check("tax_sync", {15'd0, sync}, 16'd1);
        check("lda_A", {8'd0, dut.r_a}, 16'h0005);
        step(2);
        check("inx_fetch", a, 16'h8003);
        check("tax_X", {8'd0, dut.r_x}, 16'h0005);
        step(2);
        check("jmp_fetch", a, 16'h8004);
        check("jmp_sync", {15'd0, sync}, 16'd1);
        check("inx_X", {8'd0, dut.r_x}, 16'h0006);
        check("inx_N", {15'd0, dut.r_p[c_p_n]}, 16'd0);
        check("inx_Z", {15'd0, dut.r_p[c_p_z]}, 16'd0);
        step(1);
        check("jmp_t1", a, 16'h8005);
        step(1);
        check("jmp_t2", a, 16'h8006);
        step(1);
        check("loop_fetch", a, 16'h8000);
        check("loop_sync", {15'd0, sync}, 16'd1);
        for (int k = 0; k < 2; k++) begin
            step(9);
            check("loop_repeat", a, 16'h8000);
            check("loop_repeat_sync", {15'd0, sync}, 16'd1);
        end

        // LDA $1234
        clear_mem();
        load(64'hAD34120000000000, 3);
        mem[16'h1234] = 8'h80;
        do_reset();
        step(3);
        check("abs_t3_a", a, 16'h1234);
        check("abs_t3_sync", {15'd0, sync}, 16'd0);
        step(1);
        check("abs_next_fetch", a, 16'h8003);
        check("abs_A", {8'd0, dut.r_a}, 16'h0080);
        check("abs_N", {15'd0, dut.r_p[c_p_n]}, 16'd1);
        check("abs_Z", {15'd0, dut.r_p[c_p_z]}, 16'd0);

        // SEC / LDA #7F / ADC #00 / CMP #80
        clear_mem();
        load(64'h38A97F6900C98000, 7);
        do_reset();
        step(2);
        check("sec_C", {15'd0, dut.r_p[c_p_c]}, 16'd1);
        step(4);
        check("adc_fetch", a, 16'h8005);
        check("adc_A", {8'd0, dut.r_a}, 16'h0080);
        check("adc_V", {15'd0, dut.r_p[c_p_v]}, 16'd1);
        check("adc_N", {15'd0, dut.r_p[c_p_n]}, 16'd1);
        check("adc_C", {15'd0, dut.r_p[c_p_c]}, 16'd0);
        step(2);
        check("cmp_Z", {15'd0, dut.r_p[c_p_z]}, 16'd1);
        check("cmp_C", {15'd0, dut.r_p[c_p_c]}, 16'd1);
        check("cmp_N", {15'd0, dut.r_p[c_p_n]}, 16'd0);
        check("cmp_A", {8'd0, dut.r_a}, 16'h0080);

        // LDX #00 / BEQ +2 / (skipped) / BNE +5 / BEQ -2
        clear_mem();
        load(64'hA200F002EAEAD005, 8);
        mem[16'h8008] = 8'hF0;
        mem[16'h8009] = 8'hFE;
        do_reset();
        step(2);
        check("beq_fetch", a, 16'h8002);
        step(1);
        check("beq_t1", a, 16'h8003);
        step(1);
        check("beq_t2", a, 16'h8004);
        check("beq_t2_sync", {15'd0, sync}, 16'd0);
        step(1);
        check("beq_target", a, 16'h8006);
        check("beq_target_sync", {15'd0, sync}, 16'd1);
        step(2);
        check("bne_not_taken", a, 16'h8008);
        check("bne_sync", {15'd0, sync}, 16'd1);
        step(3);
        check("beq_back", a, 16'h8008);
        check("beq_back_sync", {15'd0, sync}, 16'd1);
        step(3);
        check("beq_back2", a, 16'h8008);

        // Asynchronous reset in T2 of JMP
        clear_mem();
        load(64'h4C00800000000000, 3);
        do_reset();
        step(2);
        check("jmp_t2_pre", a, 16'h8002);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_a", a, 16'hFFFC);
        check("async_rst_sync", {15'd0, sync}, 16'd0);
        do_reset();

        // Undefined opcode 02 followed by LDA #11
        clear_mem();
        load(64'h02A9110000000000, 3);
        do_reset();
        step(1);
        check("undef_t1_a", a, 16'h8001);
        check("undef_t1_sync", {15'd0, sync}, 16'd0);
`ifdef K6502_UNDEF_HALT_EN
        step(5);
        check("halt_a", a, 16'h8001);
        check("halt_sync", {15'd0, sync}, 16'd0);
`else
        step(1);
        check("undef_next_fetch", a, 16'h8001);
        check("undef_next_sync", {15'd0, sync}, 16'd1);
        step(2);
        check("undef_lda_A", {8'd0, dut.r_a}, 16'h0011);
        check("undef_after_fetch", a, 16'h8003);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
